// File: rtl/memory_arb_pkg.sv
// Shared types for the two-client memory arbiter: requester id and the
// response tag carried from grant cycle to response cycle.
package memory_arb_pkg;

  localparam int NUM_REQ = 2;

  typedef logic req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
    logic    was_read;
    logic    err;
  } resp_tag_t;

endpackage

// File: rtl/memory_arbiter_if.sv
// Client and memory-side signals of the arbiter; slave = arbiter view,
// master = everything around it (clients plus the memory instance).
interface memory_arbiter_if #(
  parameter int DATA_W    = 8,
  parameter int ADDR_SIZE = 4
);
  logic                 req0, req1;
  logic                 we0, we1;
  logic [ADDR_SIZE-1:0] addr0, addr1;
  logic [DATA_W-1:0]    wdata0, wdata1;
  logic                 gnt0, gnt1;
  logic                 rvalid0, rvalid1;
  logic [DATA_W-1:0]    rdata0, rdata1;
  logic                 err0, err1;
  logic                 mem_write, mem_read;
  logic [ADDR_SIZE-1:0] mem_addr_w, mem_addr_r;
  logic [DATA_W-1:0]    mem_datain;
  logic [DATA_W-1:0]    mem_dataout;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1,
    output mem_write, mem_read, mem_addr_w, mem_addr_r, mem_datain,
    input  mem_dataout
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1,
    input  mem_write, mem_read, mem_addr_w, mem_addr_r, mem_datain,
    output mem_dataout
  );
endinterface

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter: onehot grant from req, priority flips to the
// other client after every grant and holds when nothing is granted.
module rr_arbiter_2
  import memory_arb_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  req_id_t prio;
  req_id_t prio_next;

  always_ff @(posedge clock) begin
    if (reset) prio <= 1'b0;
    else       prio <= prio_next;
  end

  always_comb begin
    prio_next = prio;
    if (gnt[0])      prio_next = 1'b1;
    else if (gnt[1]) prio_next = 1'b0;
  end

  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) gnt = prio ? 2'b10 : 2'b01;
    else              gnt = req;
  end

endmodule

// File: rtl/memory_arbiter.sv
// Shares one single-port registered-read memory between two clients; the
// response (data or error) returns to the winner one cycle after its grant.
module memory_arbiter
  import memory_arb_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MEM_SIZE  = 6,
  parameter int ADDR_SIZE = $clog2(MEM_SIZE) + 1
) (
  input  logic             clock,
  input  logic             reset,
  memory_arbiter_if.slave  bus
);

  localparam logic [ADDR_SIZE-1:0] MEM_LIMIT = ADDR_SIZE'(MEM_SIZE);

  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ-1:0]   gnt;
  logic                 granted;
  req_id_t              win_id;
  logic                 win_we;
  logic [ADDR_SIZE-1:0] win_addr;
  logic [DATA_W-1:0]    win_wdata;
  logic                 out_of_range;
  logic [ADDR_SIZE-1:0] mem_addr;
  resp_tag_t            tag;
  logic                 rd_hit;

  assign req = {bus.req1, bus.req0};

  rr_arbiter_2 u_rr (
    .clock (clock),
    .reset (reset),
    .req   (req),
    .gnt   (gnt)
  );

  assign granted  = |gnt;
  assign win_id   = gnt[1];
  assign bus.gnt0 = gnt[0];
  assign bus.gnt1 = gnt[1];

  always_comb begin
    win_we    = bus.we0;
    win_addr  = bus.addr0;
    win_wdata = bus.wdata0;
    if (win_id) begin
      win_we    = bus.we1;
      win_addr  = bus.addr1;
      win_wdata = bus.wdata1;
    end
  end

  assign out_of_range = (win_addr >= MEM_LIMIT);

  // Out-of-range accesses still present the address but never strobe the array.
  always_comb begin
    bus.mem_write  = 1'b0;
    bus.mem_read   = 1'b0;
    mem_addr       = '0;
    bus.mem_datain = '0;
    if (granted) begin
      mem_addr       = win_addr;
      bus.mem_datain = win_wdata;
      bus.mem_write  = win_we && !out_of_range;
      bus.mem_read   = !win_we && !out_of_range;
    end
  end

  assign bus.mem_addr_w = mem_addr;
  assign bus.mem_addr_r = mem_addr;

  always_ff @(posedge clock) begin
    if (reset) begin
      tag <= '0;
    end else if (granted) begin
      tag <= '{valid: 1'b1, id: win_id, was_read: !win_we, err: out_of_range};
    end else begin
      tag <= '0;
    end
  end

  assign rd_hit      = tag.valid && tag.was_read && !tag.err;
  assign bus.rvalid0 = tag.valid && (tag.id == 1'b0);
  assign bus.rvalid1 = tag.valid && (tag.id == 1'b1);
  assign bus.err0    = bus.rvalid0 && tag.err;
  assign bus.err1    = bus.rvalid1 && tag.err;
  assign bus.rdata0  = (rd_hit && (tag.id == 1'b0)) ? bus.mem_dataout : '0;
  assign bus.rdata1  = (rd_hit && (tag.id == 1'b1)) ? bus.mem_dataout : '0;

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: directed scenarios then random
// traffic, checked against a word-array model of the shared memory.
module tb_memory_arbiter;

  localparam int DW = 8;
  localparam int MS = 6;
  localparam int AW = 4;

  typedef struct {
    int          id;
    bit          err;
    logic [7:0]  rdata;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  memory_arbiter_if #(.DATA_W(DW), .ADDR_SIZE(AW)) bus ();

  memory_arbiter #(.DATA_W(DW), .MEM_SIZE(MS), .ADDR_SIZE(AW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // memory instance the arbiter fronts: write strobe, registered read
  logic [7:0] tbmem [16] = '{default: 8'h00};
  always @(posedge clock) begin
    if (bus.mem_write) tbmem[bus.mem_addr_w] <= bus.mem_datain;
    if (bus.mem_read)  bus.mem_dataout <= tbmem[bus.mem_addr_r];
  end

  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_en   = 0;
  exp_t exp_q[$];

  // reference state
  logic [7:0] m_mem [MS] = '{default: 8'h00};
  int         m_prio = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic do_cycle(input bit rst,
                          input bit r0, input bit w0, input logic [3:0] a0, input logic [7:0] d0,
                          input bit r1, input bit w1, input logic [3:0] a1, input logic [7:0] d1,
                          output int win);
    exp_t       e;
    logic [3:0] a;
    logic [7:0] d;
    bit         we, oor;
    @(negedge clock);
    reset = rst;
    bus.req0 = r0; bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0;
    bus.req1 = r1; bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1;
    #1;
    if (r0 && r1)  win = m_prio;
    else if (r0)   win = 0;
    else if (r1)   win = 1;
    else           win = -1;
    chk("gnt0", bus.gnt0, win == 0);
    chk("gnt1", bus.gnt1, win == 1);
    if (win < 0) begin
      chk("idle_mem_write", bus.mem_write, 0);
      chk("idle_mem_read", bus.mem_read, 0);
      chk("idle_addr_w", bus.mem_addr_w, 0);
      chk("idle_addr_r", bus.mem_addr_r, 0);
      chk("idle_datain", bus.mem_datain, 0);
    end else begin
      a   = (win == 1) ? a1 : a0;
      d   = (win == 1) ? d1 : d0;
      we  = (win == 1) ? w1 : w0;
      oor = (a >= MS);
      chk("mem_write", bus.mem_write, we && !oor);
      chk("mem_read", bus.mem_read, !we && !oor);
      if (!oor) begin
        chk("mem_addr_w", bus.mem_addr_w, a);
        chk("mem_addr_r", bus.mem_addr_r, a);
      end
      if (we && !oor) chk("mem_datain", bus.mem_datain, d);
      e.id    = win;
      e.err   = oor;
      e.rdata = (!we && !oor) ? m_mem[a] : 8'h00;
      if (we && !oor) m_mem[a] = d;
      if (!rst) exp_q.push_back(e);
      m_prio = 1 - win;
    end
    if (rst) m_prio = 0;
  endtask

  // response monitor: one expected entry per response cycle, else all quiet
  always @(negedge clock) begin
    exp_t e;
    if (mon_en) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rvalid0", bus.rvalid0, e.id == 0);
        chk("rvalid1", bus.rvalid1, e.id == 1);
        chk("err0", bus.err0, (e.id == 0) && e.err);
        chk("err1", bus.err1, (e.id == 1) && e.err);
        chk("rdata0", bus.rdata0, (e.id == 0) ? e.rdata : 8'h00);
        chk("rdata1", bus.rdata1, (e.id == 1) ? e.rdata : 8'h00);
      end else begin
        chk("quiet_rvalid", {bus.rvalid1, bus.rvalid0}, 0);
        chk("quiet_err", {bus.err1, bus.err0}, 0);
        chk("quiet_rdata", {bus.rdata1, bus.rdata0}, 0);
      end
    end
  end

  initial begin
    int         win;
    bit         pend [2];
    bit         pwe [2];
    logic [3:0] paddr [2];
    logic [7:0] pdat [2];
    int         wait_c [2];
    bit         rst;

    bus.req0 = 0; bus.we0 = 0; bus.addr0 = 0; bus.wdata0 = 0;
    bus.req1 = 0; bus.we1 = 0; bus.addr1 = 0; bus.wdata1 = 0;

    do_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, win);
    do_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, win);
    mon_en = 1;
    do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, win);

    // write then read back on client 0
    do_cycle(0, 1, 1, 4'd3, 8'hA5, 0, 0, 0, 0, win);
    do_cycle(0, 1, 0, 4'd3, 8'h00, 0, 0, 0, 0, win);

    // both held from reset: grants alternate starting with client 0
    do_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, win);
    for (int i = 0; i < 4; i++) begin
      do_cycle(0, 1, 0, 4'd3, 8'h00, 1, 0, 4'(i), 8'h00, win);
      chk("alternate", win, i % 2);
    end

    // back-to-back write/read on client 1, same address
    do_cycle(0, 0, 0, 0, 0, 1, 1, 4'd5, 8'h3C, win);
    do_cycle(0, 0, 0, 0, 0, 1, 0, 4'd5, 8'h00, win);

    // first illegal address and all-ones
    do_cycle(0, 1, 0, 4'd6, 8'h00, 0, 0, 0, 0, win);
    do_cycle(0, 1, 0, 4'd15, 8'h00, 0, 0, 0, 0, win);
    do_cycle(0, 1, 1, 4'd6, 8'h77, 0, 0, 0, 0, win);
    do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, win);

    // grant to client 1 squashed by reset; priority back to client 0
    do_cycle(0, 0, 0, 0, 0, 1, 0, 4'd1, 8'h00, win);
    do_cycle(1, 0, 0, 0, 0, 1, 1, 4'd2, 8'h11, win);
    do_cycle(0, 1, 0, 4'd2, 8'h00, 1, 0, 4'd2, 8'h00, win);
    chk("post_reset_prio", win, 0);

    // random held requests
    pend = '{0, 0};
    wait_c = '{0, 0};
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && $urandom_range(0, 3) != 0) begin
          pend[i]   = 1;
          pwe[i]    = 1'($urandom_range(0, 1));
          paddr[i]  = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(6, 15))
                                                  : 4'($urandom_range(0, 5));
          pdat[i]   = 8'($urandom_range(0, 255));
          wait_c[i] = 0;
        end
      end
      rst = ($urandom_range(0, 49) == 0);
      do_cycle(rst, pend[0], pwe[0], paddr[0], pdat[0],
                    pend[1], pwe[1], paddr[1], pdat[1], win);
      if (win >= 0) pend[win] = 0;
      for (int i = 0; i < 2; i++) begin
        if (pend[i]) begin
          wait_c[i]++;
          chk("grant_latency", wait_c[i] < 2, 1);
        end
      end
    end

    do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, win);
    do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, win);
    chk("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
